expr_result_checker: RTL

Downstream consumer of the 90-bit packed result bus `y` from a vloghammer expression block. It accepts one result per valid/ready handshake together with the golden vector from the reference model. It compares the two field by field across all 18 packed fields y0..y17 and counts mismatches. It records the first failure and folds every accepted result into a MISR signature for regression sign-off.

---
 rtl/expr_chk_pkg.sv | 30 +++
 rtl/expr_chk_misr.sv | 25 ++
 rtl/expr_result_checker.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/expr_chk_pkg.sv
// rtl/expr_chk_pkg.sv - shared types, field layout and helpers for expr_result_checker
package expr_chk_pkg;

    localparam int Y_W    = 90;
    localparam int NFIELD = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Field 0 sits in the MSBs; widths follow the 4,5,6 pattern six times.
    localparam int FIELD_W [NFIELD] = '{4, 5, 6, 4, 5, 6, 4, 5, 6,
                                        4, 5, 6, 4, 5, 6, 4, 5, 6};
    localparam int FIELD_LSB [NFIELD] = '{86, 81, 75, 71, 66, 60, 56, 51, 45,
                                          41, 36, 30, 26, 21, 15, 11,  6,  0};

    // Lowest set bit index of a field-mismatch vector (0 if none set).
    function automatic logic [4:0] lowest_set(input logic [NFIELD-1:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = NFIELD - 1; i >= 0; i--) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/expr_chk_misr.sv
// rtl/expr_chk_misr.sv - multiple-input signature register with clear and enable
module expr_chk_misr #(
    parameter int               SIG_W    = 32,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(32'h04C11DB7)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] sig
);

    // Shift left, apply polynomial feedback from the MSB, fold in new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : '0) ^ data;
        end
    end

endmodule

// File: rtl/expr_result_checker.sv
// rtl/expr_result_checker.sv - field-wise result checker with first-fail capture; MISR under EXPR_CHK_SIG_EN
module expr_result_checker #(
    parameter int               Y_W      = 90,
    parameter int               CNT_W    = 16,
    parameter int               SIG_W    = 32,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(32'h04C11DB7)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Y_W-1:0]   in_y,
    input  logic [Y_W-1:0]   in_exp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [4:0]       first_fail_field,
    output logic [SIG_W-1:0] signature
);
    import expr_chk_pkg::*;

    state_t             state;
    logic [CNT_W-1:0]   num_lat;
    logic [CNT_W-1:0]   acc_cnt;
    logic               xfer;
    logic               clr;
    logic               s1_valid;
    logic [Y_W-1:0]     s1_y;
    logic [Y_W-1:0]     s1_exp;
    logic [CNT_W-1:0]   s1_idx;
    logic [Y_W-1:0]     diff;
    logic [NFIELD-1:0]  field_mis;

    assign xfer = in_valid && in_ready;
    assign clr  = start && ((state == IDLE) || (state == DONE));
    assign diff = s1_y ^ s1_exp;

    for (genvar g = 0; g < NFIELD; g++) begin : g_field
        assign field_mis[g] = |diff[FIELD_LSB[g] +: FIELD_W[g]];
    end

    // Run control: start/latch, accept count, drain the compare stage, hold results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            num_lat  <= '0;
            acc_cnt  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        num_lat <= num_vectors;
                        acc_cnt <= '0;
                        if (num_vectors == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            pass     <= 1'b1;
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                        end else begin
                            state    <= RUN;
                            done     <= 1'b0;
                            pass     <= 1'b0;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        acc_cnt <= acc_cnt + 1'b1;
                        if (acc_cnt == num_lat - 1'b1) begin
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!s1_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (mismatch_cnt == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: capture the accepted pair and its vector index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_y     <= '0;
            s1_exp   <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_y   <= in_y;
                s1_exp <= in_exp;
                s1_idx <= acc_cnt;
            end
        end
    end

    // Stage 2: saturating mismatch count and first-failure capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt     <= '0;
            first_fail_idx   <= '0;
            first_fail_field <= '0;
        end else if (clr) begin
            mismatch_cnt     <= '0;
            first_fail_idx   <= '0;
            first_fail_field <= '0;
        end else if (s1_valid && (|field_mis)) begin
            if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
            if (mismatch_cnt == '0) begin
                first_fail_idx   <= s1_idx;
                first_fail_field <= lowest_set(field_mis);
            end
        end
    end

`ifdef EXPR_CHK_SIG_EN
    logic [SIG_W-1:0] fold;
    assign fold = SIG_W'(s1_y[31:0] ^ s1_y[63:32] ^ {6'b0, s1_y[89:64]});

    expr_chk_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (s1_valid),
        .data  (fold),
        .sig   (signature)
    );
`else
    logic unused_sig_poly;
    assign unused_sig_poly = ^SIG_POLY;
    assign signature       = '0;
`endif

endmodule
